// File: rtl/sim_pipe_logger_if.sv
// Host pipe-out port of the simulation logger: pop strobe, head-of-FIFO word, block-ready flag.
interface sim_pipe_logger_if;
  logic        ep_read;
  logic [15:0] ep_datain;
  logic        ep_ready;

  // Host / okBTPipeOut side
  modport master (output ep_read, input ep_datain, input ep_ready);
  // Logger side
  modport slave  (input ep_read, output ep_datain, output ep_ready);
endinterface

// File: rtl/sim_pipe_logger.sv
// Packs two 32-bit channels per sim_clk tick into four 16-bit words and queues
// them in a first-word-fall-through FIFO for host readback over a BTPipeOut.
module sim_pipe_logger #(
  parameter int unsigned AW          = 10,
  parameter int unsigned BLOCK_WORDS = 256
) (
  input  logic                clk,
  input  logic                reset_global,
  input  logic                reset_sim,
  input  logic                sample_clk,
  input  logic                arm,
  input  logic [31:0]         ch0,
  input  logic [31:0]         ch1,
  sim_pipe_logger_if.slave    ep,
  output logic [AW:0]         fill_count,
  output logic [31:0]         frame_cnt,
  output logic                overflow
);

  typedef enum logic [2:0] {IDLE, CHECK, W0, W1, W2, W3} state_t;

  localparam logic [AW+1:0] DEPTH       = {2'b01, {AW{1'b0}}};
  localparam logic [AW:0]   READY_LEVEL = (AW+1)'(BLOCK_WORDS);

  state_t        state;
  logic          s1, s2, s3, strobe;
  logic          take;
  logic [63:0]   shadow;
  logic [63:0]   pend_data;
  logic          pending;
  logic [15:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;
  logic [15:0]   wr_word;
  logic [AW+1:0] free_words;

  assign take = strobe & arm;

  // Synchronise sim_clk and emit a one-cycle strobe one cycle after its rising edge
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      strobe <= 1'b0;
    end else begin
      s1     <= sample_clk;
      s2     <= s1;
      s3     <= s2;
      strobe <= s2 & ~s3;
    end
  end

  // Word select for the write states, pop qualification and free space
  always_comb begin
    wr_en   = 1'b0;
    wr_word = '0;
    case (state)
      W0: begin wr_en = 1'b1; wr_word = shadow[15:0];  end
      W1: begin wr_en = 1'b1; wr_word = shadow[31:16]; end
      W2: begin wr_en = 1'b1; wr_word = shadow[47:32]; end
      W3: begin wr_en = 1'b1; wr_word = shadow[63:48]; end
      default: ;
    endcase
    rd_en      = ep.ep_read && (fill_count != '0);
    free_words = DEPTH - {1'b0, fill_count};
  end

  // Frame FSM: latch, check space, write four words; one-deep pending slot for early strobes
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      state     <= IDLE;
      shadow    <= '0;
      pend_data <= '0;
      pending   <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else if (reset_sim) begin
      state     <= IDLE;
      shadow    <= '0;
      pend_data <= '0;
      pending   <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      // Strobes outside IDLE go to the pending slot; a second one is lost
      if (take && state != IDLE) begin
        if (pending) begin
          overflow <= 1'b1;
        end else begin
          pending   <= 1'b1;
          pend_data <= {ch1, ch0};
        end
      end
      case (state)
        IDLE: begin
          // Pending frame is older, so it goes first; a coinciding strobe refills the slot
          if (pending) begin
            shadow  <= pend_data;
            pending <= take;
            if (take) pend_data <= {ch1, ch0};
            state   <= CHECK;
          end else if (take) begin
            shadow <= {ch1, ch0};
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (free_words >= (AW+2)'(4)) begin
            state <= W0;
          end else begin
            overflow <= 1'b1;
            state    <= IDLE;
          end
        end
        W0: state <= W1;
        W1: state <= W2;
        W2: state <= W3;
        W3: begin
          frame_cnt <= frame_cnt + 32'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; no reset needed since pointers and fill_count define validity
  always_ff @(posedge clk) begin
    if (wr_en && !reset_sim) mem[wr_ptr] <= wr_word;
  end

  // FIFO pointers, occupancy and registered block-ready flag
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_count  <= '0;
      ep.ep_ready <= 1'b0;
    end else if (reset_sim) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_count  <= '0;
      ep.ep_ready <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   fill_count <= fill_count + (AW+1)'(1);
        2'b01:   fill_count <= fill_count - (AW+1)'(1);
        default: ;
      endcase
      ep.ep_ready <= (fill_count >= READY_LEVEL);
    end
  end

  // First-word-fall-through head; zero when empty
  always_comb begin
    ep.ep_datain = (fill_count != '0) ? mem[rd_ptr] : '0;
  end

endmodule
